// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin N:1 multiplexer.
package mux_pkg;

  localparam int MAX_CH = 16;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the search starts one past ptr and wraps at N.
// Purely combinational; en gates the one-hot grant but not the index/any outputs.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]               req,
  input  logic [clog2_min1(N)-1:0]   ptr,
  input  logic                       en,
  output logic [N-1:0]               gnt_onehot,
  output logic [clog2_min1(N)-1:0]   gnt_idx,
  output logic                       any
);

  localparam int SEL_W = clog2_min1(N);

  logic             found;
  logic [SEL_W-1:0] cand;
  int               pos;

  // Walk the channels in priority order and take the first requester.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    pos        = 0;
    any        = |req;
    for (int k = 1; k <= N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      cand = SEL_W'(pos);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (en && found) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mux_rr_nx1.sv
// N-input, W-bit round-robin multiplexer with valid/ready on every port and a
// single registered output stage (one-cycle latency, one beat per cycle).
// Build option MUX_RR_PKT_LOCK_EN: adds in_last/out_last and holds the grant on
// one channel until that channel sends a beat with its last flag set.
module mux_rr_nx1
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [N*W-1:0]   in_data,
`ifdef MUX_RR_PKT_LOCK_EN
  input  logic [N-1:0]     in_last,
  output logic             out_last,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel
);

  logic             can_load;
  logic             xfer;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             any_req;
  logic [SEL_W-1:0] ptr;
  logic [W-1:0]     sel_data;

  assign can_load = !out_valid || out_ready;

`ifdef MUX_RR_PKT_LOCK_EN
  logic             lock;
  logic [SEL_W-1:0] lock_idx;
  logic [N-1:0]     lock_mask;

  // While a packet is open only the owning channel may compete.
  always_comb begin
    lock_mask           = '0;
    lock_mask[lock_idx] = 1'b1;
    req                 = lock ? (in_valid & lock_mask) : in_valid;
  end
`else
  assign req = in_valid;
`endif

  rr_arbiter #(.N(N)) u_arb (
    .req        (req),
    .ptr        (ptr),
    .en         (can_load),
    .gnt_onehot (gnt),
    .gnt_idx    (gnt_idx),
    .any        (any_req)
  );

  assign in_ready = gnt;
  assign xfer     = can_load && any_req;

  // Constant-index slice select keeps the data path a plain N:1 mux.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_idx == SEL_W'(k)) sel_data = in_data[k*W +: W];
    end
  end

  // Output register, last-grant pointer and (optionally) packet lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SEL_W'(N - 1);
`ifdef MUX_RR_PKT_LOCK_EN
      out_last  <= 1'b0;
      lock      <= 1'b0;
      lock_idx  <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= gnt_idx;
`ifdef MUX_RR_PKT_LOCK_EN
      out_last  <= in_last[gnt_idx];
      if (in_last[gnt_idx]) begin
        lock <= 1'b0;
        ptr  <= gnt_idx;
      end else begin
        lock     <= 1'b1;
        lock_idx <= gnt_idx;
      end
`else
      ptr       <= gnt_idx;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Self-checking bench for mux_rr_nx1 (N=4, W=8), default build or MUX_RR_PKT_LOCK_EN.
module tb_mux_rr_nx1;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     in_valid = '0;
  logic [N-1:0]     in_ready;
  logic [W-1:0]     dat [N];
  logic [N*W-1:0]   in_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
`ifdef MUX_RR_PKT_LOCK_EN
  logic [N-1:0]     in_last = '1;
  logic             out_last;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign in_data[k*W +: W] = dat[k];
  end

  always #5 clk = ~clk;

  mux_rr_nx1 #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef MUX_RR_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: registered output state plus arbitration pointer/lock.
  int m_ptr = N - 1, m_valid = 0, m_data = 0, m_sel = 0, m_last = 0, m_lock = 0, m_lch = 0;
  int n_ptr = N - 1, n_valid = 0, n_data = 0, n_sel = 0, n_last = 0, n_lock = 0, n_lch = 0;

  function automatic int exp_grant();
    int c;
    if (m_valid != 0 && !out_ready) return -1;
    for (int k = 1; k <= N; k++) begin
      c = (m_ptr + k) % N;
      if (m_lock != 0 && c != m_lch) continue;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= N - 1; m_valid <= 0; m_data <= 0; m_sel <= 0;
      m_last <= 0; m_lock <= 0; m_lch <= 0;
    end else begin
      m_ptr <= n_ptr; m_valid <= n_valid; m_data <= n_data; m_sel <= n_sel;
      m_last <= n_last; m_lock <= n_lock; m_lch <= n_lch;
    end
  end

  // Compare every cycle on the falling edge, then compute the model's next state.
  initial begin
    int g;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        g = exp_grant();
        chk("in_ready", int'(in_ready), (g < 0) ? 0 : (1 << g));
        chk("out_valid", int'(out_valid), m_valid);
        chk("out_data", int'(out_data), m_data);
        chk("out_sel", int'(out_sel), m_sel);
`ifdef MUX_RR_PKT_LOCK_EN
        chk("out_last", int'(out_last), m_last);
`endif
        n_ptr = m_ptr; n_valid = m_valid; n_data = m_data; n_sel = m_sel;
        n_last = m_last; n_lock = m_lock; n_lch = m_lch;
        if (g >= 0) begin
          n_valid = 1; n_data = int'(dat[g]); n_sel = g;
`ifdef MUX_RR_PKT_LOCK_EN
          n_last = int'(in_last[g]);
          if (in_last[g]) begin n_lock = 0; n_ptr = g; end
          else begin n_lock = 1; n_lch = g; end
`else
          n_ptr = g;
`endif
        end else if (m_valid != 0 && out_ready) begin
          n_valid = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) dat[k] = 8'hA0 + W'(k);

    // Reset, then idle.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_data", int'(out_data), 0);
    chk("rst out_sel", int'(out_sel), 0);
    chk("rst in_ready", int'(in_ready), 0);

    // All four requesting, consumer always ready.
    tick();
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      chk("rr out_sel", int'(out_sel), k % 4);
      chk("rr out_data", int'(out_data), 'hA0 + (k % 4));
      chk("rr out_valid", int'(out_valid), 1);
    end

    // Backpressure while holding the ch2 beat.
    tick();
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("bp in_ready", int'(in_ready), 0);
      chk("bp out_data", int'(out_data), 'hA2);
      chk("bp out_sel", int'(out_sel), 2);
      tick();
      if (j == 2) out_ready = 1'b1;
    end
    tick();
    in_valid = 4'b0100;
    @(negedge clk);
    chk("bp release sel", int'(out_sel), 3);
    chk("bp release data", int'(out_data), 'hA3);

    // Single requester ch2 is granted every cycle.
    for (int j = 0; j < 4; j++) begin
      tick();
      if (j == 3) in_valid = 4'b0000;
      @(negedge clk);
      chk("single sel", int'(out_sel), 2);
      if (j < 3) chk("single in_ready", int'(in_ready), 4'b0100);
    end
    tick();
    @(negedge clk);
    chk("drain out_valid", int'(out_valid), 0);
    tick();
    in_valid = 4'b1011;
    tick();
    in_valid = 4'b1111;
    @(negedge clk);
    chk("no idle rotation sel", int'(out_sel), 3);

    // Asynchronous reset between clock edges with a beat in flight.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async out_valid", int'(out_valid), 0);
    chk("async out_sel", int'(out_sel), 0);
    chk("async out_data", int'(out_data), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
`ifdef MUX_RR_PKT_LOCK_EN
    in_valid = 4'b0111; in_last = 4'b0101;
    @(negedge clk);
    chk("post reset sel", int'(out_sel), 0);
    tick();
    @(negedge clk);
    chk("lock sel 1", int'(out_sel), 1);
    chk("lock last 1", int'(out_last), 0);
    tick();
    in_last = 4'b0111;
    @(negedge clk);
    chk("lock sel 2", int'(out_sel), 1);
    chk("lock last 2", int'(out_last), 0);
    tick();
    @(negedge clk);
    chk("lock sel 3", int'(out_sel), 1);
    chk("lock last 3", int'(out_last), 1);
    tick();
    in_valid = 4'b0000;
    @(negedge clk);
    chk("unlock sel", int'(out_sel), 2);
    chk("unlock last", int'(out_last), 1);
`else
    in_valid = 4'b0000;
    @(negedge clk);
    chk("post reset sel", int'(out_sel), 0);
    chk("post reset data", int'(out_data), 'hA0);
`endif
    repeat (3) tick();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
